clkgen_multi: RTL and testbench

CLKGEN_MULTI -- requirements
Module: clkgen_multi

---
 rtl/clkgen_pkg.sv | 31 +++
 rtl/clkgen_chan.sv | 68 ++++++
 rtl/clkgen_multi.sv | 131 +++++++++++++
 tb/tb_clkgen_multi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared constants, request bundle and slot states
// for the multi-channel refclk divider.
package clkgen_pkg;

    localparam int DIV_W_DEF  = 8;
    localparam int DIV_W_MAX  = 16;
    localparam int CHAN_W_MAX = 5;

    typedef struct packed {
        logic [CHAN_W_MAX-1:0] chan;
        logic [DIV_W_MAX-1:0]  div;
        logic [DIV_W_MAX-1:0]  phase;
        logic [DIV_W_MAX-1:0]  high;
    } cfg_req;

    typedef enum logic [1:0] {
        ST_HALT,
        ST_IDLE,
        ST_PEND
    } slot_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clkgen_chan.sv
// clkgen_chan: one divided output channel; counter, high-time compare
// and a reconfiguration swap that only happens at the period boundary.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int               DIV_W    = DIV_W_DEF,
    parameter logic [DIV_W-1:0] INIT_DIV = DIV_W'(8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             apply,
    input  logic [DIV_W-1:0] new_div,
    input  logic [DIV_W-1:0] new_phase,
    input  logic [DIV_W-1:0] new_high,
    output logic             outclk,
    output logic             outen,
    output logic             applied
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] high_q, high_d;
    logic             outclk_q, outclk_d;
    logic             wrap;

    // Advance the counter; swap config only on the last count of a period
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        high_d   = high_q;
        outclk_d = 1'b0;
        applied  = 1'b0;
        wrap     = (cnt_q == div_q - DIV_W'(1));
        if (run) begin
            outclk_d = (cnt_q < high_q);
            if (!wrap) begin
                cnt_d = cnt_q + DIV_W'(1);
            end else if (apply) begin
                cnt_d   = new_phase;
                div_d   = new_div;
                high_d  = new_high;
                applied = 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Channel state registers; reset restores the build-time ratio
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            div_q    <= INIT_DIV;
            high_q   <= INIT_DIV >> 1;
            outclk_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            high_q   <= high_d;
            outclk_q <= outclk_d;
        end
    end

    assign outclk = outclk_q;
    assign outen  = run && (cnt_q == '0);

endmodule

// File: rtl/clkgen_multi.sv
// clkgen_multi: NUM_CLOCKS refclk dividers with a one-deep config slot
// and lock tracking. CLKGEN_DUTY_EN enables programmable high time.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int                          NUM_CLOCKS  = 3,
    parameter int                          DIV_W       = DIV_W_DEF,
    parameter logic [NUM_CLOCKS*DIV_W-1:0] DIV_INIT    = {8'd2, 8'd4, 8'd8},
    parameter int                          LOCK_CYCLES = 16,
    localparam int CHAN_W = (NUM_CLOCKS > 1) ? clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_phase,
    input  logic [DIV_W-1:0]      cfg_high,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outen,
    output logic                  locked
);

    localparam int                LOCK_W   = clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

    slot_state_t           state_q, state_d;
    cfg_req                pend_q, pend_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                  err_q, err_d;
    logic                  hs;
    logic                  bad;
    logic                  bad_duty;
    logic [DIV_W-1:0]      req_high;
    logic [NUM_CLOCKS-1:0] apply;
    logic [NUM_CLOCKS-1:0] applied;
    logic                  run;
    logic                  unused_bits;

`ifdef CLKGEN_DUTY_EN
    assign req_high = cfg_high;
    assign bad_duty = (cfg_high == '0) || (cfg_high >= cfg_div);
`else
    assign req_high = cfg_div >> 1;
    assign bad_duty = 1'b0;
`endif

    assign unused_bits = ^{pend_q, cfg_high};

    assign run       = (state_q != ST_HALT);
    assign cfg_ready = (state_q == ST_IDLE);
    assign hs        = cfg_valid && cfg_ready;
    assign bad       = (cfg_div < DIV_W'(2))
                    || (cfg_phase >= cfg_div)
                    || (32'(cfg_chan) >= NUM_CLOCKS)
                    || bad_duty;

    // Slot FSM: halt one cycle after reset, then accept/hold/release
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        err_d      = 1'b0;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            ST_HALT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (hs) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = ST_PEND;
                        pend_d.chan  = CHAN_W_MAX'(cfg_chan);
                        pend_d.div   = DIV_W_MAX'(cfg_div);
                        pend_d.phase = DIV_W_MAX'(cfg_phase);
                        pend_d.high  = DIV_W_MAX'(req_high);
                    end
                end
            end
            ST_PEND: begin
                if (|applied) state_d = ST_IDLE;
            end
            default: state_d = ST_HALT;
        endcase
        if (hs && !bad) begin
            lock_cnt_d = '0;
        end else if (state_q != ST_PEND && lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
    end

    // Slot, lock counter and error pulse registers
    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q    <= ST_HALT;
            pend_q     <= '0;
            lock_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            lock_cnt_q <= lock_cnt_d;
            err_q      <= err_d;
        end
    end

    assign cfg_err = err_q;
    assign locked  = (lock_cnt_q == LOCK_MAX);

    for (genvar k = 0; k < NUM_CLOCKS; k++) begin : g_chan
        assign apply[k] = (state_q == ST_PEND)
                       && (pend_q.chan == CHAN_W_MAX'(k));
        clkgen_chan #(
            .DIV_W    (DIV_W),
            .INIT_DIV (DIV_INIT[k*DIV_W +: DIV_W])
        ) u_chan (
            .clk       (refclk),
            .rst       (rst),
            .run       (run),
            .apply     (apply[k]),
            .new_div   (pend_q.div[DIV_W-1:0]),
            .new_phase (pend_q.phase[DIV_W-1:0]),
            .new_high  (pend_q.high[DIV_W-1:0]),
            .outclk    (outclk[k]),
            .outen     (outen[k]),
            .applied   (applied[k])
        );
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: directed checks of clkgen_multi with default
// parameters; extra duty-cycle checks when CLKGEN_DUTY_EN is defined.
module tb_clkgen_multi;

    logic       refclk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic [7:0] cfg_high;
    logic       cfg_err;
    logic [2:0] outclk;
    logic [2:0] outen;
    logic       locked;

    int n_chk  = 0;
    int n_fail = 0;
    int t      = 0;

    always #5 refclk = ~refclk;

    clkgen_multi dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .outclk    (outclk),
        .outen     (outen),
        .locked    (locked)
    );

    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
        t++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic put(input int ch, input int dv, input int ph, input int hi);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_div   = 8'(dv);
        cfg_phase = 8'(ph);
        cfg_high  = 8'(hi);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_outclk", 32'(outclk), 32'd0);
        chk("rst_outen", 32'(outen), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        rst = 1'b1;
        tick();
        t = 0;
        chk("rel_ready", 32'(cfg_ready), 32'd1);
        chk("rel_outen", 32'(outen), 32'd7);
        chk("rel_outclk", 32'(outclk), 32'd0);
    endtask

    task automatic run_init(input int n);
        logic [2:0] eo;
        logic [2:0] ee;
        int d;
        for (int s = 1; s <= n; s++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                d = (k == 0) ? 8 : (k == 1) ? 4 : 2;
                eo[k] = ((s - 1) % d) < (d / 2);
                ee[k] = (s % d) == 0;
            end
            chk("init_outclk", 32'(outclk), 32'(eo));
            chk("init_outen", 32'(outen), 32'(ee));
            chk("init_locked", 32'(locked), 32'(s >= 15));
        end
    endtask

    function automatic logic [2:0] exp_mid(input int tt);
        logic [2:0] v;
        v[0] = ((tt - 52) % 5) < 2;
        v[1] = ((tt - 1) % 4) < 2;
        v[2] = ((tt - 1) % 2) < 1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] tbl0;
        logic [9:0] tbl1;
        int bc[3];
        int bd[3];
        int bp[3];
        bc = '{0, 0, 3};
        bd = '{1, 4, 4};
        bp = '{0, 6, 0};
        tbl0 = 10'b1000110000;
        tbl1 = 10'b0111000110;

        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        cfg_high  = '0;

        do_reset();
        run_init(40);

        repeat (3) tick();
        chk("w1_ready_pre", 32'(cfg_ready), 32'd1);
        put(0, 5, 2, 2);
        tick();
        cfg_valid = 1'b0;
        chk("w1_ready_acc", 32'(cfg_ready), 32'd0);
        chk("w1_locked_drop", 32'(locked), 32'd0);
        chk("w1_err", 32'(cfg_err), 32'd0);
        repeat (3) begin
            tick();
            chk("w1_ready_wait", 32'(cfg_ready), 32'd0);
        end
        while (t < 64) begin
            tick();
            chk("w1_ready_back", 32'(cfg_ready), 32'd1);
            if (t <= 57) chk("w1_outclk0", 32'(outclk[0]), 32'(tbl0[t-48]));
            chk("w1_outen0", 32'(outen[0]),
                32'((t >= 51) && ((t - 51) % 5 == 0)));
            chk("w1_locked", 32'(locked), 32'(t >= 64));
        end

        for (int i = 0; i < 3; i++) begin
            put(bc[i], bd[i], bp[i], 1);
            tick();
            cfg_valid = 1'b0;
            chk("bad_err_hi", 32'(cfg_err), 32'd1);
            chk("bad_ready", 32'(cfg_ready), 32'd1);
            chk("bad_locked", 32'(locked), 32'd1);
            chk("bad_outclk", 32'(outclk), 32'(exp_mid(t)));
            tick();
            chk("bad_err_lo", 32'(cfg_err), 32'd0);
            chk("bad_locked2", 32'(locked), 32'd1);
            chk("bad_outclk2", 32'(outclk), 32'(exp_mid(t)));
        end
        while (t < 75) begin
            tick();
            chk("bad_after", 32'(outclk), 32'(exp_mid(t)));
        end

        put(2, 4, 0, 2);
        tick();
        chk("b2b_ready76", 32'(cfg_ready), 32'd0);
        put(1, 6, 1, 3);
        tick();
        chk("b2b_ready77", 32'(cfg_ready), 32'd0);
        tick();
        chk("b2b_ready78", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        chk("b2b_ready79", 32'(cfg_ready), 32'd0);
        chk("b2b_outclk2_79", 32'(outclk[2]), 32'd1);
        while (t < 89) begin
            tick();
            if (t == 80) chk("b2b_ready80", 32'(cfg_ready), 32'd1);
            chk("b2b_outclk2", 32'(outclk[2]), 32'(((t - 79) % 4) < 2));
            chk("b2b_outclk1", 32'(outclk[1]), 32'(tbl1[t-80]));
        end

        put(0, 3, 0, 1);
        tick();
        cfg_valid = 1'b0;
        chk("pend_ready", 32'(cfg_ready), 32'd0);
        do_reset();
        run_init(20);

`ifdef CLKGEN_DUTY_EN
        begin
            int hi;
            int lo;
            int lim;
            put(0, 10, 0, 10);
            tick();
            cfg_valid = 1'b0;
            chk("duty_err", 32'(cfg_err), 32'd1);
            put(0, 10, 0, 3);
            tick();
            cfg_valid = 1'b0;
            lim = 0;
            while (!cfg_ready && lim < 12) begin
                tick();
                lim++;
            end
            chk("duty_apply_to", 32'(cfg_ready), 32'd1);
            lim = 0;
            while (outclk[0] && lim < 20) begin tick(); lim++; end
            while (!outclk[0] && lim < 20) begin tick(); lim++; end
            hi = 0;
            lo = 0;
            while (outclk[0] && hi < 20) begin tick(); hi++; end
            while (!outclk[0] && lo < 20) begin tick(); lo++; end
            chk("duty_high", 32'(hi), 32'd3);
            chk("duty_low", 32'(lo), 32'd7);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
